// File: rtl/pcie_cpld_tx.sv
// pcie_cpld_tx: builds PCIe Completion-with-Data TLPs for BAR reads and streams them onto the
// 16-bit core transmit interface, fetching payload DWs from a 1-cycle-latency read port.
module pcie_cpld_tx #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = 10
) (
  input  logic          clk_125,
  input  logic          sys_rst,
  input  logic [7:0]    bus_num,
  input  logic [4:0]    dev_num,
  input  logic [2:0]    func_num,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [15:0]   req_id,
  input  logic [7:0]    req_tag,
  input  logic [2:0]    req_tc,
  input  logic [1:0]    req_attr,
  input  logic [9:0]    req_len,
  input  logic [6:0]    req_lower_addr,
  input  logic [AW-1:0] req_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          tx_req,
  input  logic          tx_rdy,
  output logic          tx_st,
  output logic          tx_end,
  output logic [15:0]   tx_data,
  output logic          len_err,
  output logic [15:0]   cpl_count
);

  localparam logic [9:0] MaxLen = 10'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StSend} state_e;

  state_e        state_q, state_d;

  // Latched descriptor
  logic [15:0]   id_q, id_d;
  logic [7:0]    tag_q, tag_d;
  logic [2:0]    tc_q, tc_d;
  logic [1:0]    attr_q, attr_d;
  logic [9:0]    len_q, len_d;
  logic [6:0]    la_q, la_d;

  // Word index within the TLP and payload fetch pipeline
  logic [11:0]   w_q, w_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          rd_vld_q;
  logic [31:0]   pend_q, pend_d;
  logic [31:0]   dw_q, dw_d;

  logic          len_err_q, len_err_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          accept;
  logic          len_ok;
  logic          word_acc;
  logic          last_word;
  logic [11:0]   w_last;
  logic [11:0]   rd_limit;

  assign accept    = (state_q == StIdle) && req_valid;
  assign len_ok    = (req_len != 10'd0) && (req_len <= MaxLen);
  assign word_acc  = (state_q == StSend) && tx_rdy;
  // Last word index is 5 + 2*len; reads are issued on even words below 4 + 2*len
  assign w_last    = {1'b0, len_q, 1'b0} + 12'd5;
  assign rd_limit  = {1'b0, len_q, 1'b0} + 12'd4;
  assign last_word = (w_q == w_last);

  assign len_err   = len_err_q;
  assign cpl_count = cnt_q;

  // State register
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept && len_ok) state_d = StReq;
      StReq:   if (tx_rdy) state_d = StSend;
      StSend:  if (tx_rdy && last_word) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: handshake, TLP word mux and payload read strobe
  always_comb begin
    req_ready = (state_q == StIdle);
    tx_req    = (state_q == StReq);
    tx_st     = 1'b0;
    tx_end    = 1'b0;
    tx_data   = 16'h0000;
    rd_en     = 1'b0;
    rd_addr   = '0;
    if (state_q == StSend) begin
      tx_st  = (w_q == 12'd0);
      tx_end = last_word;
      case (w_q)
        12'd0:   tx_data = {8'h4A, 1'b0, tc_q, 4'h0};
        12'd1:   tx_data = {2'b00, attr_q, 2'b00, len_q};
        12'd2:   tx_data = {bus_num, dev_num, func_num};
        12'd3:   tx_data = {4'h0, len_q, 2'b00};
        12'd4:   tx_data = id_q;
        12'd5:   tx_data = {tag_q, 1'b0, la_q};
        default: tx_data = w_q[0] ? dw_q[15:0] : dw_q[31:16];
      endcase
      // Fetch DW 0 when word 4 goes out, then DW k+1 when the high half of DW k goes out
      rd_en = tx_rdy && !w_q[0] && (w_q >= 12'd4) && (w_q < rd_limit);
      if (rd_en) begin
        rd_addr = raddr_q;
      end
    end
  end

  // Datapath next-state: descriptor capture, word index, fetch pipeline, counters
  always_comb begin
    id_d      = id_q;
    tag_d     = tag_q;
    tc_d      = tc_q;
    attr_d    = attr_q;
    len_d     = len_q;
    la_d      = la_q;
    w_d       = w_q;
    raddr_d   = raddr_q;
    dw_d      = dw_q;
    cnt_d     = cnt_q;
    len_err_d = accept && !len_ok;
    pend_d    = rd_vld_q ? rd_data : pend_q;
    if (accept) begin
      id_d    = req_id;
      tag_d   = req_tag;
      tc_d    = req_tc;
      attr_d  = req_attr;
      len_d   = req_len;
      la_d    = req_lower_addr;
      w_d     = 12'd0;
      raddr_d = req_addr;
    end
    if (rd_en) begin
      raddr_d = raddr_q + AW'(1);
    end
    if (word_acc) begin
      if (last_word) begin
        w_d   = 12'd0;
        cnt_d = cnt_q + 16'd1;
      end else begin
        w_d = w_q + 12'd1;
        // Entering word 6+2k: bypass read data if it lands this very cycle
        if (w_q[0] && (w_q >= 12'd5)) begin
          dw_d = rd_vld_q ? rd_data : pend_q;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      id_q      <= '0;
      tag_q     <= '0;
      tc_q      <= '0;
      attr_q    <= '0;
      len_q     <= '0;
      la_q      <= '0;
      w_q       <= '0;
      raddr_q   <= '0;
      rd_vld_q  <= 1'b0;
      pend_q    <= '0;
      dw_q      <= '0;
      len_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      id_q      <= id_d;
      tag_q     <= tag_d;
      tc_q      <= tc_d;
      attr_q    <= attr_d;
      len_q     <= len_d;
      la_q      <= la_d;
      w_q       <= w_d;
      raddr_q   <= raddr_d;
      rd_vld_q  <= rd_en;
      pend_q    <= pend_d;
      dw_q      <= dw_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pcie_cpld_tx.sv
// tb_pcie_cpld_tx: randomized self-checking bench for the CplD transmit block.
module tb_pcie_cpld_tx;

  localparam int unsigned AW      = 10;
  localparam int unsigned MAX_LEN = 16;

  logic          clk_125 = 1'b0;
  logic          sys_rst = 1'b1;
  logic [7:0]    bus_num = 8'h12;
  logic [4:0]    dev_num = 5'd1;
  logic [2:0]    func_num = 3'd1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [15:0]   req_id = '0;
  logic [7:0]    req_tag = '0;
  logic [2:0]    req_tc = '0;
  logic [1:0]    req_attr = '0;
  logic [9:0]    req_len = '0;
  logic [6:0]    req_lower_addr = '0;
  logic [AW-1:0] req_addr = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data = '0;
  logic          tx_req;
  logic          tx_rdy = 1'b0;
  logic          tx_st;
  logic          tx_end;
  logic [15:0]   tx_data;
  logic          len_err;
  logic [15:0]   cpl_count;

  pcie_cpld_tx #(
    .MAX_LEN(MAX_LEN),
    .AW     (AW)
  ) dut (
    .clk_125       (clk_125),
    .sys_rst       (sys_rst),
    .bus_num       (bus_num),
    .dev_num       (dev_num),
    .func_num      (func_num),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_id        (req_id),
    .req_tag       (req_tag),
    .req_tc        (req_tc),
    .req_attr      (req_attr),
    .req_len       (req_len),
    .req_lower_addr(req_lower_addr),
    .req_addr      (req_addr),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .tx_req        (tx_req),
    .tx_rdy        (tx_rdy),
    .tx_st         (tx_st),
    .tx_end        (tx_end),
    .tx_data       (tx_data),
    .len_err       (len_err),
    .cpl_count     (cpl_count)
  );

  always #4 clk_125 = ~clk_125;

  // Payload memory: data is valid exactly one cycle after a read, garbage otherwise
  logic [31:0] mem [1024];
  always @(posedge clk_125) rd_data <= rd_en ? mem[rd_addr] : $urandom();

  typedef struct packed {
    logic [15:0]   id;
    logic [7:0]    tag;
    logic [2:0]    tc;
    logic [1:0]    attr;
    logic [9:0]    len;
    logic [6:0]    la;
    logic [AW-1:0] addr;
  } desc_t;

  int checks = 0;
  int errors = 0;
  int exp_cpl = 0;
  int hold_err;
  int ready_err;
  bit tlp_timeout;

  logic [17:0]   exp_q[$];
  logic [17:0]   obs_q[$];
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] rd_q[$];

  function automatic desc_t rand_desc(input int len);
    desc_t d;
    d.id   = 16'($urandom());
    d.tag  = 8'($urandom());
    d.tc   = 3'($urandom());
    d.attr = 2'($urandom());
    d.len  = 10'(len);
    d.la   = 7'($urandom());
    d.addr = AW'($urandom());
    return d;
  endfunction

  // Reference: the full word stream {st, end, data} and the DW read addresses of one completion
  function automatic void build_exp(input desc_t d);
    logic [15:0] hdr [6];
    logic [31:0] dw;
    logic [15:0] v;
    int n;
    n = 6 + 2 * int'(d.len);
    hdr[0] = {8'h4A, 1'b0, d.tc, 4'h0};
    hdr[1] = {2'b00, d.attr, 2'b00, d.len};
    hdr[2] = {bus_num, dev_num, func_num};
    hdr[3] = {4'h0, 12'((int'(d.len) * 4) % 4096)};
    hdr[4] = d.id;
    hdr[5] = {d.tag, 1'b0, d.la};
    exp_q.delete();
    exp_rd_q.delete();
    for (int k = 0; k < int'(d.len); k++) begin
      exp_rd_q.push_back(AW'((int'(d.addr) + k) % (1 << AW)));
    end
    for (int i = 0; i < n; i++) begin
      if (i < 6) begin
        v = hdr[i];
      end else begin
        dw = mem[exp_rd_q[(i - 6) / 2]];
        v  = (i % 2 == 0) ? dw[31:16] : dw[15:0];
      end
      exp_q.push_back({(i == 0), (i == n - 1), v});
    end
  endfunction

  function automatic int word_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int rd_diff();
    int n;
    n = (rd_q.size() < exp_rd_q.size()) ? rd_q.size() : exp_rd_q.size();
    for (int i = 0; i < n; i++) if (rd_q[i] !== exp_rd_q[i]) return i;
    if (rd_q.size() != exp_rd_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [17:0] obs_at(input int i);
    return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 18'hxxxxx;
  endfunction

  function automatic logic [17:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 18'hxxxxx;
  endfunction

  task automatic drive_desc(input desc_t d);
    req_id         = d.id;
    req_tag        = d.tag;
    req_tc         = d.tc;
    req_attr       = d.attr;
    req_len        = d.len;
    req_lower_addr = d.la;
    req_addr       = d.addr;
  endtask

  // Hand one descriptor over and collect the completion. mode 0: tx_rdy held high,
  // 1: 1010.. during SEND, 2: random tx_rdy throughout.
  task automatic run_tlp(input desc_t d, input int mode);
    int cyc;
    int scnt;
    bit in_send;
    bit done;
    bit go_send;
    bit prev_stall;
    logic [17:0] cur;
    logic [17:0] prev;
    obs_q.delete();
    rd_q.delete();
    hold_err    = 0;
    ready_err   = 0;
    tlp_timeout = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(posedge clk_125); #1;
      cyc++;
    end
    drive_desc(d);
    req_valid = 1'b1;
    @(posedge clk_125); #1;
    req_valid = 1'b0;
    drive_desc(rand_desc(0));
    in_send = 1'b0; done = 1'b0; prev_stall = 1'b0; prev = '0; scnt = 0; cyc = 0;
    while (!done && cyc < 3000 && obs_q.size() < 2100) begin
      if (!in_send)       tx_rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      else if (mode == 1) tx_rdy = (scnt % 2 == 0);
      else if (mode == 2) tx_rdy = 1'($urandom_range(0, 1));
      else                tx_rdy = 1'b1;
      @(negedge clk_125);
      if (req_ready) ready_err++;
      if (rd_en) rd_q.push_back(rd_addr);
      go_send = !in_send && tx_req && tx_rdy;
      if (in_send) begin
        cur = {tx_st, tx_end, tx_data};
        if (prev_stall && cur !== prev) hold_err++;
        if (tx_rdy) begin
          obs_q.push_back(cur);
          if (tx_end) done = 1'b1;
        end
        prev       = cur;
        prev_stall = !tx_rdy;
        scnt++;
      end
      @(posedge clk_125); #1;
      if (go_send) in_send = 1'b1;
      cyc++;
    end
    tlp_timeout = !done;
    tx_rdy = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tx_rdy  = 1'b1;
    repeat (3) @(posedge clk_125);
    #1;
    sys_rst = 1'b0;
    checks++;
    if ({req_ready, tx_req, tx_st, tx_end, rd_en, len_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 100000",
               {req_ready, tx_req, tx_st, tx_end, rd_en, len_err});
    end
    checks++;
    if (tx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_tx_data got %h exp 0000", tx_data);
    end
    checks++;
    if (cpl_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cpl_count got %h exp 0000", cpl_count);
    end
    checks++;
    if (rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_rd_addr got %h exp 000", rd_addr);
    end
    tx_rdy = 1'b0;
  endtask

  task automatic test_single();
    desc_t d;
    logic [15:0] words [8];
    logic [17:0] e;
    words = '{16'h4A00, 16'h0001, 16'h1209, 16'h0004, 16'h0100, 16'h0504, 16'hDEAD, 16'hBEEF};
    d = '{id: 16'h0100, tag: 8'h05, tc: 3'd0, attr: 2'd0, len: 10'd1, la: 7'h04, addr: 10'h020};
    mem[10'h020] = 32'hDEADBEEF;
    run_tlp(d, 0);
    exp_cpl++;
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL single_count got %0d exp 8", obs_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      e = {(i == 0), (i == 7), words[i]};
      checks++;
      if (obs_at(i) !== e) begin
        errors++;
        $display("FAIL single_word%0d got %h exp %h", i, obs_at(i), e);
      end
    end
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== 10'h020) begin
      errors++;
      $display("FAIL single_rd got %0d reads first %h exp 1 read 020", rd_q.size(),
               (rd_q.size() > 0) ? rd_q[0] : 10'h3FF);
    end
    checks++;
    if (cpl_count !== 16'(exp_cpl)) begin
      errors++;
      $display("FAIL single_cpl_count got %h exp %h", cpl_count, 16'(exp_cpl));
    end
  endtask

  task automatic test_stall();
    desc_t d;
    int idx;
    d = rand_desc(4);
    d.addr = 10'h010;
    build_exp(d);
    run_tlp(d, 1);
    exp_cpl++;
    idx = word_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL stall_words idx %0d got %h exp %h", idx, obs_at(idx), exp_at(idx));
    end
    checks++;
    if (obs_at(3) !== 18'h00010) begin
      errors++;
      $display("FAIL stall_w3 got %h exp 00010", obs_at(3));
    end
    idx = rd_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL stall_rd_addr idx %0d got %0d reads exp 010..013", idx, rd_q.size());
    end
    checks++;
    if (hold_err !== 0 || ready_err !== 0 || tlp_timeout) begin
      errors++;
      $display("FAIL stall_hold got hold %0d ready %0d timeout %0d exp 0 0 0",
               hold_err, ready_err, tlp_timeout);
    end
  endtask

  task automatic test_back_to_back();
    desc_t d;
    int idx;
    for (int t = 0; t < 2; t++) begin
      d = rand_desc((t == 0) ? 2 : 16);
      build_exp(d);
      run_tlp(d, 0);
      exp_cpl++;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_after%0d got %b exp 1", t, req_ready);
      end
      idx = word_diff();
      checks++;
      if (idx >= 0) begin
        errors++;
        $display("FAIL b2b_words%0d idx %0d got %h exp %h", t, idx, obs_at(idx), exp_at(idx));
      end
      checks++;
      if (ready_err !== 0 || tlp_timeout || rd_diff() >= 0) begin
        errors++;
        $display("FAIL b2b_busy%0d got ready_high %0d timeout %0d rd_diff %0d exp 0 0 -1",
                 t, ready_err, tlp_timeout, rd_diff());
      end
    end
    checks++;
    if (obs_at(3) !== 18'h00040) begin
      errors++;
      $display("FAIL b2b_w3 got %h exp 00040", obs_at(3));
    end
    checks++;
    if (cpl_count !== 16'(exp_cpl)) begin
      errors++;
      $display("FAIL b2b_cpl_count got %h exp %h", cpl_count, 16'(exp_cpl));
    end
  endtask

  task automatic test_len_err();
    int req_seen;
    int lens [2];
    lens = '{0, MAX_LEN + 1};
    req_seen = 0;
    tx_rdy = 1'b1;
    for (int t = 0; t < 2; t++) begin
      drive_desc(rand_desc(lens[t]));
      req_valid = 1'b1;
      @(posedge clk_125); #1;
      req_valid = 1'b0;
      checks++;
      if (len_err !== 1'b1 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL len_err_pulse%0d got err %b ready %b exp 1 1", t, len_err, req_ready);
      end
      if (tx_req) req_seen++;
      @(posedge clk_125); #1;
      checks++;
      if (len_err !== 1'b0) begin
        errors++;
        $display("FAIL len_err_clear%0d got %b exp 0", t, len_err);
      end
    end
    repeat (10) begin
      if (tx_req) req_seen++;
      @(posedge clk_125); #1;
    end
    checks++;
    if (req_seen !== 0) begin
      errors++;
      $display("FAIL len_err_tx_req got %0d cycles exp 0", req_seen);
    end
    checks++;
    if (cpl_count !== 16'(exp_cpl)) begin
      errors++;
      $display("FAIL len_err_cpl_count got %h exp %h", cpl_count, 16'(exp_cpl));
    end
    tx_rdy = 1'b0;
  endtask

  task automatic test_random();
    desc_t d;
    int idx;
    for (int t = 0; t < 6; t++) begin
      d = rand_desc(int'($urandom_range(1, MAX_LEN)));
      if (t == 0) d.addr = 10'h3FE;
      build_exp(d);
      run_tlp(d, 2);
      exp_cpl++;
      idx = word_diff();
      checks++;
      if (idx >= 0) begin
        errors++;
        $display("FAIL rand%0d_words idx %0d got %h exp %h", t, idx, obs_at(idx), exp_at(idx));
      end
      idx = rd_diff();
      checks++;
      if (idx >= 0) begin
        errors++;
        $display("FAIL rand%0d_rd_addr idx %0d got %0d reads exp %0d", t, idx, rd_q.size(),
                 exp_rd_q.size());
      end
      checks++;
      if (hold_err !== 0 || ready_err !== 0 || tlp_timeout) begin
        errors++;
        $display("FAIL rand%0d_hold got hold %0d ready %0d timeout %0d exp 0 0 0",
                 t, hold_err, ready_err, tlp_timeout);
      end
    end
    checks++;
    if (cpl_count !== 16'(exp_cpl)) begin
      errors++;
      $display("FAIL rand_cpl_count got %h exp %h", cpl_count, 16'(exp_cpl));
    end
  endtask

  task automatic test_reset_mid();
    desc_t d;
    int cyc;
    int idx;
    d = rand_desc(4);
    build_exp(d);
    drive_desc(d);
    req_valid = 1'b1;
    @(posedge clk_125); #1;
    req_valid = 1'b0;
    tx_rdy = 1'b1;
    cyc = 0;
    while (!tx_req && cyc < 20) begin
      @(posedge clk_125); #1;
      cyc++;
    end
    @(posedge clk_125); #1;
    repeat (7) @(posedge clk_125);
    #1;
    checks++;
    if ({tx_st, tx_end, tx_data} !== exp_at(7)) begin
      errors++;
      $display("FAIL mid_w7 got %h exp %h", {tx_st, tx_end, tx_data}, exp_at(7));
    end
    sys_rst = 1'b1;
    @(posedge clk_125); #1;
    checks++;
    if ({req_ready, tx_req, tx_st, tx_end, rd_en, len_err} !== 6'b100000 ||
        tx_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b data %h exp 100000 data 0000",
               {req_ready, tx_req, tx_st, tx_end, rd_en, len_err}, tx_data);
    end
    checks++;
    if (cpl_count !== 16'h0000 || rd_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset_cnt got cpl %h rd_addr %h exp 0000 000", cpl_count, rd_addr);
    end
    sys_rst = 1'b0;
    tx_rdy  = 1'b0;
    exp_cpl = 0;
    d = rand_desc(1);
    build_exp(d);
    run_tlp(d, 0);
    exp_cpl++;
    idx = word_diff();
    checks++;
    if (idx >= 0 || tlp_timeout) begin
      errors++;
      $display("FAIL mid_after_words idx %0d got %h exp %h", idx, obs_at(idx), exp_at(idx));
    end
    checks++;
    if (cpl_count !== 16'(exp_cpl)) begin
      errors++;
      $display("FAIL mid_after_cpl_count got %h exp %h", cpl_count, 16'(exp_cpl));
    end
  endtask

  task automatic test_wrap();
    desc_t d;
    int n;
    int cyc;
    int idx;
    sys_rst = 1'b1;
    @(posedge clk_125); #1;
    sys_rst = 1'b0;
    d = rand_desc(1);
    drive_desc(d);
    tx_rdy = 1'b1;
    req_valid = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 65535 && cyc < 65535 * 12) begin
      @(negedge clk_125);
      cyc++;
      if (tx_end && tx_rdy) begin
        n++;
        if (n == 65535) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    @(posedge clk_125); #1;
    tx_rdy = 1'b0;
    checks++;
    if (n != 65535 || cpl_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h after %0d TLPs exp FFFF after 65535", cpl_count, n);
    end
    d = rand_desc(1);
    build_exp(d);
    run_tlp(d, 0);
    idx = word_diff();
    checks++;
    if (cpl_count !== 16'h0000 || idx >= 0) begin
      errors++;
      $display("FAIL wrap_rollover got %h word_diff %0d exp 0000 -1", cpl_count, idx);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_len_err();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
